// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I types and constants for the fetch front end and decoder
package riscv_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic {RUN, FAULT} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - synchronous FIFO of fetched {pc, inst} entries with flush
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a full buffer can still take a push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Entry storage; no reset needed since only slots below count are ever presented.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush empties the buffer and overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!resetn) push |-> (!full || pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!resetn) pop |-> !empty);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32I fetch front end: PC, credit-limited imem requests, redirect/flush
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault
);

  localparam int          CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   in_flight;
  logic [CW-1:0]   in_flight_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic            credit_ok;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic            buf_empty;
  logic            buf_full;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  // Dropped-but-outstanding requests still hold credit, so the buffer can never overflow.
  assign credit_ok      = ({1'b0, in_flight} + {1'b0, count}) < DEPTH_W;
  // Gating with resetn keeps the request quiet while reset is held.
  assign imem_req_valid = resetn && (state == RUN) && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign in_flight_nxt  = in_flight + CW'(req_fire) - CW'(imem_rsp_valid);

  assign push       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign push_entry = '{pc: rsp_pc, inst: imem_rsp_data};

  assign inst_valid = !buf_empty && (state == RUN);
  assign pop        = inst_valid && inst_ready;
  assign inst       = inst_valid ? head.inst : NOP_INST;
  assign inst_pc    = inst_valid ? head.pc : rsp_pc;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  // PC and credit bookkeeping; a redirect marks every request still outstanding after this cycle as stale.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc  <= RESET_PC;
      rsp_pc    <= RESET_PC;
      in_flight <= '0;
      drop_cnt  <= '0;
    end else begin
      in_flight <= in_flight_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop_cnt <= in_flight_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push)     rsp_pc   <= rsp_pc + 32'd4;
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // Fetch FSM: a misaligned redirect parks the unit in FAULT until an aligned redirect arrives.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= RUN;
      fetch_fault <= 1'b0;
    end else if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        state       <= FAULT;
        fetch_fault <= 1'b1;
      end else begin
        state       <= RUN;
        fetch_fault <= 1'b0;
      end
    end
  end

  a_rsp_expected: assert property (@(posedge clk) disable iff (!resetn) imem_rsp_valid |-> (in_flight != '0));
  a_credit:       assert property (@(posedge clk) disable iff (!resetn) ({1'b0, in_flight} + {1'b0, count}) <= DEPTH_W);
  a_drop_bound:   assert property (@(posedge clk) disable iff (!resetn) drop_cnt <= in_flight);
  a_full_stall:   assert property (@(posedge clk) disable iff (!resetn) buf_full |-> !imem_req_valid);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit with imem model and stream scoreboard
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] target;
    logic        exp_fault;
    logic [31:0] exp_pc;
  } redir_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready, fetch_fault;
  logic [31:0] inst, inst_pc;

  logic        imem_req_valid_b, imem_req_ready_b, imem_rsp_valid_b;
  logic [31:0] imem_req_addr_b, imem_rsp_data_b;
  logic        redirect_valid_b;
  logic [31:0] redirect_pc_b;
  logic        inst_valid_b, inst_ready_b, fetch_fault_b;
  logic [31:0] inst_b, inst_pc_b;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .fetch_fault(fetch_fault)
  );

  instr_fetch_unit #(.RESET_PC(RST_PC2), .BUF_DEPTH(DEPTH)) dut_b (
    .clk(clk), .resetn(resetn),
    .imem_req_valid(imem_req_valid_b), .imem_req_ready(imem_req_ready_b), .imem_req_addr(imem_req_addr_b),
    .imem_rsp_valid(imem_rsp_valid_b), .imem_rsp_data(imem_rsp_data_b),
    .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
    .inst_valid(inst_valid_b), .inst_ready(inst_ready_b), .inst(inst_b), .inst_pc(inst_pc_b),
    .fetch_fault(fetch_fault_b)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_due;
  req_t        q[$];
  int          buf_exp, stale_left, pops, acc_total, req_since, cap_b;
  logic        fault_exp, got_first, rsp_now, rsp_stale, acc_b;
  logic [31:0] fetch_exp, exp_pc, first_pc, addr_b;
  int          lat_lo, lat_hi, ir_mode;
  logic        rdy_rand, rand_redir;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_ready_inputs();
    imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    inst_ready     = (ir_mode == 2) ? 1'($urandom_range(0, 1)) : (ir_mode == 1);
  endtask

  task automatic do_reset();
    resetn         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_valid_b = 1'b0;
    imem_rsp_data_b  = '0;
    q.delete();
    buf_exp = 0; stale_left = 0; acc_total = 0; req_since = 0;
    fault_exp = 1'b0; got_first = 1'b0; rsp_now = 1'b0; rsp_stale = 1'b0; acc_b = 1'b0;
    fetch_exp = 32'h0; exp_pc = 32'h0; first_pc = 32'h0; addr_b = 32'h0;
    set_ready_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, NOP_INST);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_b_inst_pc", inst_pc_b, RST_PC2);
    @(posedge clk);
    #1;
    cyc++;
    last_due = cyc;
    resetn   = 1'b1;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model and drive the next cycle.
  task automatic tick();
    int   lat;
    int   due;
    int   sel;
    logic pop;
    req_t r;
    @(negedge clk);
    chk("req_valid", imem_req_valid,
        !fault_exp && !redirect_valid && ((q.size() + int'(rsp_now) + buf_exp) < DEPTH));
    if (imem_req_valid) chk("req_addr", imem_req_addr, fetch_exp);
    chk("fetch_fault", fetch_fault, fault_exp);
    chk("inst_valid", inst_valid, buf_exp > 0);
    if (!inst_valid) chk("inst_nop", inst, NOP_INST);
    pop = inst_valid && inst_ready;
    if (pop && !redirect_valid) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_data", inst, mem_word(exp_pc));
      if (!got_first) begin
        got_first = 1'b1;
        first_pc  = inst_pc;
      end
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (imem_req_valid && imem_req_ready) begin
      lat = $urandom_range(lat_hi, lat_lo);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      q.push_back('{addr: imem_req_addr, due: due});
      fetch_exp = fetch_exp + 32'd4;
      acc_total++;
      req_since++;
    end
    if (redirect_valid) begin
      buf_exp    = 0;
      stale_left = q.size();
      fetch_exp  = redirect_pc;
      exp_pc     = redirect_pc;
      fault_exp  = (redirect_pc[1:0] != 2'b00);
      got_first  = 1'b0;
      req_since  = 0;
    end else begin
      buf_exp = buf_exp + ((rsp_now && !rsp_stale) ? 1 : 0) - (pop ? 1 : 0);
    end
    chk("no_overflow", (q.size() + buf_exp) <= DEPTH, 1);
    if (inst_valid_b && cap_b < 3) begin
      chk("b_inst_pc", inst_pc_b, RST_PC2 + 32'(4 * cap_b));
      chk("b_inst_data", inst_b, mem_word(RST_PC2 + 32'(4 * cap_b)));
      cap_b++;
    end
    acc_b  = imem_req_valid_b;
    addr_b = imem_req_addr_b;

    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    rsp_now        = 1'b0;
    rsp_stale      = 1'b0;
    if (q.size() > 0 && q[0].due <= cyc) begin
      r = q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(r.addr);
      rsp_now        = 1'b1;
      if (stale_left > 0) begin
        rsp_stale = 1'b1;
        stale_left--;
      end
    end
    imem_rsp_valid_b = acc_b;
    imem_rsp_data_b  = mem_word(addr_b);
    set_ready_inputs();
    if (rand_redir && $urandom_range(0, 19) == 0) begin
      sel            = $urandom_range(0, 9);
      redirect_valid = 1'b1;
      redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
      if (sel == 0)      redirect_pc = redirect_pc | 32'($urandom_range(1, 3));
      else if (sel == 1) redirect_pc = 32'hFFFF_FFF0 | (redirect_pc & 32'hC);
    end
  endtask

  redir_vec_t vecs [7];
  int         p0;

  initial begin
    vecs[0] = '{target: 32'h0000_0100, exp_fault: 1'b0, exp_pc: 32'h0000_0100};
    vecs[1] = '{target: 32'h0000_0102, exp_fault: 1'b1, exp_pc: 32'h0};
    vecs[2] = '{target: 32'h0000_0200, exp_fault: 1'b0, exp_pc: 32'h0000_0200};
    vecs[3] = '{target: 32'h0000_0003, exp_fault: 1'b1, exp_pc: 32'h0};
    vecs[4] = '{target: 32'h0000_0041, exp_fault: 1'b1, exp_pc: 32'h0};
    vecs[5] = '{target: 32'hFFFF_FFFC, exp_fault: 1'b0, exp_pc: 32'hFFFF_FFFC};
    vecs[6] = '{target: 32'h0000_0040, exp_fault: 1'b0, exp_pc: 32'h0000_0040};

    imem_req_ready_b = 1'b1;
    redirect_valid_b = 1'b0;
    redirect_pc_b    = '0;
    inst_ready_b     = 1'b1;
    cap_b = 0; pops = 0;
    lat_lo = 1; lat_hi = 1; ir_mode = 1; rdy_rand = 1'b0; rand_redir = 1'b0;

    // Streaming from reset; the second instance covers the PC wrap from 0xFFFF_FFF8.
    do_reset();
    repeat (12) tick();
    chk("t1_got_first", got_first, 1);
    chk("t1_first_pc", first_pc, 32'h0);
    chk("t1_rate", pops >= 4, 1);
    chk("t5_b_captured", cap_b, 3);

    // Decoder stalled: exactly DEPTH words fetched, then requests stop until it drains.
    ir_mode = 0;
    do_reset();
    repeat (10) tick();
    chk("t2_accepted", acc_total, DEPTH);
    chk("t2_req_stalled", imem_req_valid, 0);
    chk("t2_head_valid", inst_valid, 1);
    ir_mode    = 1;
    inst_ready = 1'b1;
    p0 = pops;
    repeat (12) tick();
    chk("t2_drained", (pops - p0) >= DEPTH, 1);

    // Two requests outstanding at a redirect: both stale words must vanish.
    lat_lo = 3; lat_hi = 3;
    do_reset();
    repeat (2) tick();
    chk("t3_credit_stall", imem_req_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    repeat (14) tick();
    chk("t3_got_first", got_first, 1);
    chk("t3_first_pc", first_pc, 32'h0000_0100);
    lat_lo = 1; lat_hi = 1;

    // Table of redirect targets, including misaligned ones that must park the unit.
    for (int i = 0; i < 7; i++) begin
      redirect_valid = 1'b1;
      redirect_pc    = vecs[i].target;
      repeat (8) tick();
      chk("vec_fault", fetch_fault, vecs[i].exp_fault);
      if (vecs[i].exp_fault) begin
        chk("vec_no_requests", req_since, 0);
        chk("vec_no_inst", inst_valid, 0);
      end else begin
        chk("vec_got_first", got_first, 1);
        chk("vec_first_pc", first_pc, vecs[i].exp_pc);
      end
    end

    // Random backpressure, latency and redirects against the stream model.
    rdy_rand = 1'b1; lat_lo = 1; lat_hi = 3; ir_mode = 2; rand_redir = 1'b1;
    p0 = pops;
    repeat (3000) tick();
    rand_redir = 1'b0;
    chk("rand_progress", (pops - p0) > 100, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
